// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter that lets NREQ requesters take turns writing one shared register,
// with an optional HOLD-cycle ownership window after every write.
module reg_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int HOLD  = 2,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   data,
  output logic [NREQ-1:0]         grant,
  output logic [WIDTH-1:0]        q,
  output logic                    q_valid,
  output logic [IW-1:0]           owner,
  output logic                    busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [7:0]    HOLD_M1  = (HOLD > 0) ? 8'(HOLD - 1) : 8'd0;
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

  state_t            state_r;
  logic [7:0]        cnt_r;
  logic [IW-1:0]     ptr_r;
  logic [WIDTH-1:0]  q_r;
  logic              q_valid_r;
  logic [IW-1:0]     owner_r;

  logic              found_s;
  logic [IW-1:0]     pick_s;
  logic [IW-1:0]     ptr_next_s;
  logic [WIDTH-1:0]  slice_s [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign slice_s[i] = data[i*WIDTH +: WIDTH];
  end

  // Cyclic search for the first active request at or after the priority pointer.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found_s && req[(int'(ptr_r) + k) % NREQ]) begin
        found_s = 1'b1;
        pick_s  = IW'((int'(ptr_r) + k) % NREQ);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer moves just past the winner, wrapping for non-power-of-two NREQ.
  always_comb begin
    if (pick_s == LAST_IDX) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = pick_s + IW'(1);
    end
  end

  // Grant is only ever issued from IDLE and never while reset is asserted.
  always_comb begin
    grant = '0;
    if (!reset && (state_r == ST_IDLE) && found_s) begin
      grant[pick_s] = 1'b1;
    end else begin
      grant = '0;
    end
  end

  // Ownership FSM: capture on a grant edge, then sit out HOLD cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 8'd0;
      ptr_r     <= '0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
      owner_r   <= '0;
    end else begin
      q_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            q_r       <= slice_s[pick_s];
            owner_r   <= pick_s;
            ptr_r     <= ptr_next_s;
            q_valid_r <= 1'b1;
            if (HOLD > 0) begin
              state_r <= ST_BUSY;
              cnt_r   <= HOLD_M1;
            end else begin
              state_r <= ST_IDLE;
              cnt_r   <= 8'd0;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (cnt_r == 8'd0) begin
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 8'd0;
        end
      endcase
    end
  end

  assign q       = q_r;
  assign q_valid = q_valid_r;
  assign owner   = owner_r;
  assign busy    = (state_r == ST_BUSY);

endmodule
